// File: rtl/execute_stage_if.sv
// execute_stage_if: ID/EX inputs, forwarding/control inputs and the EX/MEM register outputs.
// master drives ID/EX, forwarding, wb_data, mem_stall and flush; slave (the EX stage) drives ex_stall and ex_mem_*.
interface execute_stage_if #(
  parameter int XLEN     = 32,
  parameter int ALU_OP_W = 4
);
  logic                id_ex_valid;
  logic [XLEN-1:0]     id_ex_rs1_data;
  logic [XLEN-1:0]     id_ex_rs2_data;
  logic [XLEN-1:0]     id_ex_imm;
  logic [4:0]          id_ex_rd;
  logic [ALU_OP_W-1:0] id_ex_alu_op;
  logic                id_ex_alu_src;
  logic                id_ex_regwrite;
  logic                id_ex_memread;
  logic                id_ex_memwrite;
  logic [1:0]          forwardA;
  logic [1:0]          forwardB;
  logic [XLEN-1:0]     wb_data;
  logic                mem_stall;
  logic                flush;
  logic                ex_stall;
  logic                ex_mem_valid;
  logic [XLEN-1:0]     ex_mem_alu_result;
  logic [XLEN-1:0]     ex_mem_store_data;
  logic [4:0]          ex_mem_rd;
  logic                ex_mem_regwrite;
  logic                ex_mem_memread;
  logic                ex_mem_memwrite;

  modport master (
    output id_ex_valid, id_ex_rs1_data, id_ex_rs2_data,
    output id_ex_imm, id_ex_rd, id_ex_alu_op, id_ex_alu_src,
    output id_ex_regwrite, id_ex_memread, id_ex_memwrite,
    output forwardA, forwardB, wb_data, mem_stall, flush,
    input  ex_stall, ex_mem_valid, ex_mem_alu_result,
    input  ex_mem_store_data, ex_mem_rd, ex_mem_regwrite,
    input  ex_mem_memread, ex_mem_memwrite
  );

  modport slave (
    input  id_ex_valid, id_ex_rs1_data, id_ex_rs2_data,
    input  id_ex_imm, id_ex_rd, id_ex_alu_op, id_ex_alu_src,
    input  id_ex_regwrite, id_ex_memread, id_ex_memwrite,
    input  forwardA, forwardB, wb_data, mem_stall, flush,
    output ex_stall, ex_mem_valid, ex_mem_alu_result,
    output ex_mem_store_data, ex_mem_rd, ex_mem_regwrite,
    output ex_mem_memread, ex_mem_memwrite
  );
endinterface

// File: rtl/execute_stage.sv
// execute_stage: EX stage with operand forwarding, ALU, iterative MUL and the EX/MEM register.
// Ports: clk, rst_n (sync, active-low), ex (execute_stage_if.slave: ID/EX in, EX/MEM out).
module execute_stage #(
  parameter int XLEN     = 32,
  parameter int ALU_OP_W = 4
) (
  input logic            clk,
  input logic            rst_n,
  execute_stage_if.slave ex
);
  localparam int CW = $clog2(XLEN);
  localparam logic [ALU_OP_W-1:0] OP_MUL = ALU_OP_W'(10);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [XLEN-1:0] acc, acc_nx;
  logic [XLEN-1:0] mcand, mcand_nx;
  logic [XLEN-1:0] mplier, mplier_nx;
  logic [4:0]      m_rd, m_rd_nx;
  logic            m_rw, m_rw_nx;
  logic            m_mr, m_mr_nx;
  logic            m_mw, m_mw_nx;

  logic [XLEN-1:0] op_a, op_b, fwd_b, alu_res;
  logic [CW-1:0]   shamt;
  logic            ld, bub, stall;
  logic [XLEN-1:0] ld_res;
  logic [4:0]      ld_rd;
  logic            ld_rw, ld_mr, ld_mw;

  always_comb begin
    op_a = ex.id_ex_rs1_data;
    unique case (1'b1)
      ex.forwardA == 2'b10: op_a = ex.ex_mem_alu_result;
      ex.forwardA == 2'b01: op_a = ex.wb_data;
      default: ;
    endcase
  end

  always_comb begin
    fwd_b = ex.id_ex_rs2_data;
    unique case (1'b1)
      ex.forwardB == 2'b10: fwd_b = ex.ex_mem_alu_result;
      ex.forwardB == 2'b01: fwd_b = ex.wb_data;
      default: ;
    endcase
  end

  assign op_b  = ex.id_ex_alu_src ? ex.id_ex_imm : fwd_b;
  assign shamt = op_b[CW-1:0];

  always_comb begin
    alu_res = '0;
    case (ex.id_ex_alu_op)
      ALU_OP_W'(0):  alu_res = op_a + op_b;
      ALU_OP_W'(1):  alu_res = op_a - op_b;
      ALU_OP_W'(2):  alu_res = op_a & op_b;
      ALU_OP_W'(3):  alu_res = op_a | op_b;
      ALU_OP_W'(4):  alu_res = op_a ^ op_b;
      ALU_OP_W'(5):  alu_res = op_a << shamt;
      ALU_OP_W'(6):  alu_res = op_a >> shamt;
      ALU_OP_W'(7):  alu_res = $unsigned($signed(op_a) >>> shamt);
      ALU_OP_W'(8):
        alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      ALU_OP_W'(9):  alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
      ALU_OP_W'(11): alu_res = op_b;
      default:       alu_res = '0;
    endcase
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    acc_nx    = acc;
    mcand_nx  = mcand;
    mplier_nx = mplier;
    m_rd_nx   = m_rd;
    m_rw_nx   = m_rw;
    m_mr_nx   = m_mr;
    m_mw_nx   = m_mw;
    stall     = ex.mem_stall;
    ld        = !ex.mem_stall;
    bub       = 1'b1;
    ld_res    = alu_res;
    ld_rd     = ex.id_ex_rd;
    ld_rw     = ex.id_ex_regwrite;
    ld_mr     = ex.id_ex_memread;
    ld_mw     = ex.id_ex_memwrite;
    if (ex.flush) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (ex.id_ex_valid && ex.id_ex_alu_op == OP_MUL) begin
            state_nx  = BUSY;
            cnt_nx    = '0;
            acc_nx    = '0;
            mcand_nx  = op_a;
            mplier_nx = op_b;
            m_rd_nx   = ex.id_ex_rd;
            m_rw_nx   = ex.id_ex_regwrite;
            m_mr_nx   = ex.id_ex_memread;
            m_mw_nx   = ex.id_ex_memwrite;
            stall     = 1'b1;
          end else begin
            bub = !ex.id_ex_valid;
          end
        end
        BUSY: begin
          // shift-add: one multiplier bit per cycle
          if (mplier[0]) acc_nx = acc + mcand;
          mcand_nx  = mcand << 1;
          mplier_nx = mplier >> 1;
          cnt_nx    = cnt + 1'b1;
          stall     = 1'b1;
          if (cnt == CW'(XLEN-1)) state_nx = DONE;
        end
        DONE: begin
          if (!ex.mem_stall) begin
            state_nx = IDLE;
            bub      = 1'b0;
            ld_res   = acc;
            ld_rd    = m_rd;
            ld_rw    = m_rw;
            ld_mr    = m_mr;
            ld_mw    = m_mw;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  assign ex.ex_stall = rst_n & stall;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      m_rd   <= '0;
      m_rw   <= 1'b0;
      m_mr   <= 1'b0;
      m_mw   <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      acc    <= acc_nx;
      mcand  <= mcand_nx;
      mplier <= mplier_nx;
      m_rd   <= m_rd_nx;
      m_rw   <= m_rw_nx;
      m_mr   <= m_mr_nx;
      m_mw   <= m_mw_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex.ex_mem_valid      <= 1'b0;
      ex.ex_mem_alu_result <= '0;
      ex.ex_mem_store_data <= '0;
      ex.ex_mem_rd         <= '0;
      ex.ex_mem_regwrite   <= 1'b0;
      ex.ex_mem_memread    <= 1'b0;
      ex.ex_mem_memwrite   <= 1'b0;
    end else if (ld) begin
      ex.ex_mem_valid      <= !bub;
      ex.ex_mem_alu_result <= ld_res;
      ex.ex_mem_store_data <= fwd_b;
      ex.ex_mem_rd         <= ld_rd;
      ex.ex_mem_regwrite   <= !bub && ld_rw;
      ex.ex_mem_memread    <= !bub && ld_mr;
      ex.ex_mem_memwrite   <= !bub && ld_mw;
    end
  end
endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: directed bench for execute_stage.
// Drives ID/EX through the interface and checks EX/MEM and ex_stall.
module tb_execute_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  execute_stage_if bus ();

  execute_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ex    (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.id_ex_valid    = 1'b0;
    bus.id_ex_rs1_data = '0;
    bus.id_ex_rs2_data = '0;
    bus.id_ex_imm      = '0;
    bus.id_ex_rd       = '0;
    bus.id_ex_alu_op   = '0;
    bus.id_ex_alu_src  = 1'b0;
    bus.id_ex_regwrite = 1'b0;
    bus.id_ex_memread  = 1'b0;
    bus.id_ex_memwrite = 1'b0;
    bus.forwardA       = 2'b00;
    bus.forwardB       = 2'b00;
    bus.wb_data        = '0;
    bus.mem_stall      = 1'b0;
    bus.flush          = 1'b0;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic src,
                       input logic [4:0] rd);
    bus.id_ex_valid    = 1'b1;
    bus.id_ex_alu_op   = op;
    bus.id_ex_rs1_data = a;
    bus.id_ex_alu_src  = src;
    if (src) bus.id_ex_imm = b;
    else     bus.id_ex_rs2_data = b;
    bus.id_ex_rd       = rd;
    bus.id_ex_regwrite = 1'b1;
  endtask

  task automatic mul_run(input logic [31:0] a, input logic [31:0] b,
                         input logic src, input logic [31:0] exp);
    int n;
    issue(4'd10, a, b, src, 5'd5);
    #1;
    n = 0;
    while (bus.ex_stall && n < 40) begin
      n++;
      tick();
      if (n == 1) begin
        chk("mul_bubble", {31'b0, bus.ex_mem_valid}, 32'd0);
        bus.id_ex_rs1_data = 32'h1111;
        bus.id_ex_rs2_data = 32'h2222;
        bus.id_ex_imm      = 32'h3333;
        bus.forwardA       = 2'b01;
        bus.wb_data        = 32'd99;
      end
    end
    chk("mul_stall_cycles", n, 32'd33);
    tick();
    chk("mul_result", bus.ex_mem_alu_result, exp);
    chk("mul_valid", {31'b0, bus.ex_mem_valid}, 32'd1);
    chk("mul_rd", {27'b0, bus.ex_mem_rd}, 32'd5);
    chk("mul_regwrite", {31'b0, bus.ex_mem_regwrite}, 32'd1);
    idle();
  endtask

  logic [3:0]  t_op  [11] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5,
                              4'd6, 4'd7, 4'd8, 4'd9, 4'd11};
  logic [31:0] t_exp [11] = '{32'h8000_1024, 32'h7FFF_F1BC,
                              32'h0000_0030, 32'h8000_0FF4,
                              32'h8000_0FC4, 32'h0F00_0000,
                              32'h0000_0800, 32'hFFFF_F800,
                              32'h0000_0001, 32'h0000_0000,
                              32'h0000_0F34};

  initial begin
    // reset with random inputs
    for (int i = 0; i < 2; i++) begin
      bus.id_ex_valid    = 1'($urandom);
      bus.id_ex_rs1_data = $urandom;
      bus.id_ex_rs2_data = $urandom;
      bus.id_ex_imm      = $urandom;
      bus.id_ex_rd       = 5'($urandom);
      bus.id_ex_alu_op   = 4'($urandom);
      bus.id_ex_alu_src  = 1'($urandom);
      bus.id_ex_regwrite = 1'($urandom);
      bus.id_ex_memread  = 1'($urandom);
      bus.id_ex_memwrite = 1'($urandom);
      bus.forwardA       = 2'($urandom);
      bus.forwardB       = 2'($urandom);
      bus.wb_data        = $urandom;
      bus.mem_stall      = 1'($urandom);
      bus.flush          = 1'($urandom);
      #1;
      chk("rst_stall", {31'b0, bus.ex_stall}, 32'd0);
      tick();
    end
    chk("rst_valid", {31'b0, bus.ex_mem_valid}, 32'd0);
    chk("rst_result", bus.ex_mem_alu_result, 32'd0);
    chk("rst_store", bus.ex_mem_store_data, 32'd0);
    chk("rst_rd", {27'b0, bus.ex_mem_rd}, 32'd0);
    chk("rst_ctl", {29'b0, bus.ex_mem_regwrite, bus.ex_mem_memread,
                    bus.ex_mem_memwrite}, 32'd0);
    chk("rst_stall2", {31'b0, bus.ex_stall}, 32'd0);
    idle();
    rst_n = 1'b1;
    tick();
    chk("idle_bubble", {31'b0, bus.ex_mem_valid}, 32'd0);

    // forwarding from EX/MEM
    issue(4'd0, 32'd5, 32'd0, 1'b1, 5'd1);
    tick();
    chk("add_x1", bus.ex_mem_alu_result, 32'd5);
    chk("add_x1_rd", {27'b0, bus.ex_mem_rd}, 32'd1);
    issue(4'd0, 32'd0, 32'd3, 1'b1, 5'd2);
    bus.forwardA = 2'b10;
    tick();
    chk("fwd_exmem", bus.ex_mem_alu_result, 32'd8);
    chk("fwd_exmem_rd", {27'b0, bus.ex_mem_rd}, 32'd2);
    bus.forwardA = 2'b00;

    // forwarding from WB, and code 11 falling back to ID/EX
    issue(4'd1, 32'h30, 32'h99, 1'b0, 5'd3);
    bus.forwardB = 2'b01;
    bus.wb_data  = 32'h10;
    tick();
    chk("fwd_wb_sub", bus.ex_mem_alu_result, 32'h20);
    chk("fwd_wb_store", bus.ex_mem_store_data, 32'h10);
    bus.forwardB       = 2'b11;
    bus.id_ex_rs2_data = 32'd1;
    tick();
    chk("fwd11_sub", bus.ex_mem_alu_result, 32'h2F);
    chk("fwd11_store", bus.ex_mem_store_data, 32'd1);
    bus.forwardB = 2'b00;

    // ALU op table
    for (int i = 0; i < 11; i++) begin
      issue(t_op[i], 32'h8000_00F0, 32'h0000_0F34, 1'b1, 5'd4);
      tick();
      chk($sformatf("alu_op%0d", t_op[i]), bus.ex_mem_alu_result,
          t_exp[i]);
    end
    issue(4'd12, 32'h8000_00F0, 32'h0000_0F34, 1'b1, 5'd4);
    tick();
    chk("alu_op12", bus.ex_mem_alu_result, 32'd0);
    idle();
    tick();
    chk("invalid_bubble", {30'b0, bus.ex_mem_valid,
                           bus.ex_mem_regwrite}, 32'd0);

    // multiply
    mul_run(32'd7, 32'd6, 1'b0, 32'd42);
    mul_run(32'hFFFF_FFFF, 32'd2, 1'b1, 32'hFFFF_FFFE);

    // flush in BUSY cycle 10
    issue(4'd10, 32'd3, 32'd5, 1'b0, 5'd8);
    #1;
    tick();
    repeat (9) tick();
    chk("flush_busy_stall", {31'b0, bus.ex_stall}, 32'd1);
    bus.flush = 1'b1;
    tick();
    idle();
    #1;
    chk("flush_next_stall", {31'b0, bus.ex_stall}, 32'd0);
    chk("flush_bubble", {31'b0, bus.ex_mem_valid}, 32'd0);
    repeat (35) tick();
    chk("flush_no_prod_v", {31'b0, bus.ex_mem_valid}, 32'd0);
    chk("flush_no_prod_r", bus.ex_mem_alu_result, 32'd0);

    // mem_stall held from MUL start through DONE
    issue(4'd0, 32'h50, 32'd5, 1'b1, 5'd7);
    tick();
    chk("pre_add", bus.ex_mem_alu_result, 32'h55);
    issue(4'd10, 32'd9, 32'd9, 1'b0, 5'd6);
    bus.mem_stall = 1'b1;
    #1;
    chk("ms_start_stall", {31'b0, bus.ex_stall}, 32'd1);
    for (int i = 0; i < 33; i++) begin
      tick();
      if (i == 10)
        chk("ms_busy_hold", bus.ex_mem_alu_result, 32'h55);
    end
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("ms_done_stall%0d", k), {31'b0, bus.ex_stall}, 32'd1);
      chk($sformatf("ms_done_res%0d", k), bus.ex_mem_alu_result, 32'h55);
      chk($sformatf("ms_done_v%0d", k),
          {26'b0, bus.ex_mem_valid, bus.ex_mem_rd}, {26'b0, 1'b1, 5'd7});
      tick();
    end
    bus.mem_stall = 1'b0;
    #1;
    chk("ms_release_stall", {31'b0, bus.ex_stall}, 32'd0);
    tick();
    chk("ms_product", bus.ex_mem_alu_result, 32'd81);
    chk("ms_product_v", {26'b0, bus.ex_mem_valid, bus.ex_mem_rd},
        {26'b0, 1'b1, 5'd6});
    idle();
    tick();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
